// File: rtl/node_pkg.sv
// Shared definitions for the node comparator pipeline: relation codes and
// the width helper used to size neighbour counts and run counters.
package node_pkg;

  // Relation applied between the centre and each neighbour
  localparam logic [1:0] MODE_GT = 2'd0;
  localparam logic [1:0] MODE_GE = 2'd1;
  localparam logic [1:0] MODE_LT = 2'd2;
  localparam logic [1:0] MODE_EQ = 2'd3;

  // Bits needed to hold any value 0..n; never less than one bit
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/node_popcount.sv
// Combinational population count of N relation bits.
module node_popcount
  import node_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = cnt_width(N)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  // Sum the set bits; the total never exceeds N, so CW bits cannot overflow
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/node_cmp_pipe.sv
// Two-stage node comparator: compares a centre value against N neighbours,
// counts matches, flags the node against a runtime threshold and tracks how
// long the flag has persisted across valid results.
module node_cmp_pipe
  import node_pkg::*;
#(
  parameter  int W    = 2,
  parameter  int N    = 4,
  parameter  int HOLD = 3,
  localparam int CW   = cnt_width(N),
  localparam int HW   = cnt_width(HOLD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    in_center,
  input  logic [N*W-1:0]  in_nbr,
  input  logic [1:0]      mode,
  input  logic [CW-1:0]   thresh,
  output logic            out_valid,
  output logic            out,
  output logic [CW-1:0]   out_count,
  output logic            out_stable
);

  localparam logic [HW-1:0] HOLD_C = HW'(HOLD);

  logic [N-1:0]  rel;
  logic          s1_valid;
  logic [N-1:0]  s1_rel;
  logic [CW-1:0] s1_thresh;
  logic [CW-1:0] s1_count;
  logic          flag;
  logic [HW-1:0] run;
  logic [HW-1:0] run_next;

  for (genvar k = 0; k < N; k++) begin : g_cmp
    logic [W-1:0] nbr;
    logic         hit;

    assign nbr = in_nbr[k*W +: W];

    // Evaluate the selected unsigned relation for neighbour k
    always_comb begin
      hit = 1'b0;
      case (mode)
        MODE_GT: hit = (in_center >  nbr);
        MODE_GE: hit = (in_center >= nbr);
        MODE_LT: hit = (in_center <  nbr);
        default: hit = (in_center == nbr);
      endcase
    end

    assign rel[k] = hit;
  end

  // Stage 1: capture relation bits and threshold alongside the valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_rel    <= '0;
      s1_thresh <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_rel    <= rel;
        s1_thresh <= thresh;
      end
    end
  end

  node_popcount #(.N(N)) u_popcount (
    .bits  (s1_rel),
    .count (s1_count)
  );

  // thresh above N can never be met, and thresh 0 is always met
  assign flag = (s1_count >= s1_thresh);

  // Saturating run length of consecutive flagged results; idle cycles hold it
  always_comb begin
    run_next = run;
    if (s1_valid) begin
      if (!flag) begin
        run_next = '0;
      end else if (run != HOLD_C) begin
        run_next = run + HW'(1);
      end
    end
  end

  // Stage 2: register result, count and persistence; hold them between results
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out        <= 1'b0;
      out_count  <= '0;
      run        <= '0;
      out_stable <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      run       <= run_next;
      if (s1_valid) begin
        out        <= flag;
        out_count  <= s1_count;
        out_stable <= (run_next == HOLD_C);
      end
    end
  end

endmodule

// File: tb/tb_node_cmp_pipe.sv
// Directed bench for node_cmp_pipe: default build (W=2, N=4, HOLD=3) plus an
// N=5 build for the unreachable-threshold case.
module tb_node_cmp_pipe;
  import node_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic [1:0] in_center = '0;
  logic [7:0] in_nbr = '0;
  logic [1:0] mode = '0;
  logic [2:0] thresh = '0;
  logic       out_valid;
  logic       out_flag;
  logic [2:0] out_count;
  logic       out_stable;

  logic       v5 = 1'b0;
  logic [1:0] c5 = '0;
  logic [9:0] nbr5 = '0;
  logic [1:0] mode5 = '0;
  logic [2:0] thresh5 = '0;
  logic       ov5;
  logic       o5;
  logic [2:0] cnt5;
  logic       st5;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  node_cmp_pipe #(.W(2), .N(4), .HOLD(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_center  (in_center),
    .in_nbr     (in_nbr),
    .mode       (mode),
    .thresh     (thresh),
    .out_valid  (out_valid),
    .out        (out_flag),
    .out_count  (out_count),
    .out_stable (out_stable)
  );

  node_cmp_pipe #(.W(2), .N(5), .HOLD(3)) u_dut5 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v5),
    .in_center  (c5),
    .in_nbr     (nbr5),
    .mode       (mode5),
    .thresh     (thresh5),
    .out_valid  (ov5),
    .out        (o5),
    .out_count  (cnt5),
    .out_stable (st5)
  );

  // Inputs change on the falling edge; a sample driven at one falling edge
  // is visible on the outputs two falling edges later.
  task automatic drive(input logic v, input logic [1:0] c, input logic [7:0] nb,
                       input logic [1:0] m, input logic [2:0] th);
    @(negedge clk);
    in_valid  = v;
    in_center = c;
    in_nbr    = nb;
    mode      = m;
    thresh    = th;
  endtask

  function automatic int ref_count(input int c, input logic [7:0] nb, input int m);
    int n;
    int v;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      v = int'(nb[k*2 +: 2]);
      case (m)
        0: if (c >  v) n++;
        1: if (c >= v) n++;
        2: if (c <  v) n++;
        default: if (c == v) n++;
      endcase
    end
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_flag !== 1'b0) begin n_fail++; $display("FAIL reset_out got=%b want=0", out_flag); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", out_count); end
    n_cmp++; if (out_stable !== 1'b0) begin n_fail++; $display("FAIL reset_stable got=%b want=0", out_stable); end
    n_cmp++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL reset5_valid got=%b want=0", ov5); end
    n_cmp++; if (cnt5 !== 3'd0) begin n_fail++; $display("FAIL reset5_count got=%0d want=0", cnt5); end
    rst = 1'b0;
  endtask

  // All 1024 {center, nbr} patterns back-to-back in GE mode, thresh = N
  task automatic test_sweep();
    int idx;
    int c;
    int want_cnt;
    logic [7:0] nb;
    logic want_out;
    for (int j = 0; j < 1027; j++) begin
      if (j < 1024) drive(1'b1, 2'(j >> 8), 8'(j), MODE_GE, 3'd4);
      else          drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
      if (j >= 2) begin
        idx = j - 2;
        n_cmp++;
        if (out_valid !== (idx < 1024)) begin
          n_fail++; $display("FAIL sweep_valid idx=%0d got=%b want=%b", idx, out_valid, (idx < 1024));
        end
        if (idx < 1024) begin
          c  = idx >> 8;
          nb = 8'(idx);
          want_out = 1'b1;
          for (int k = 0; k < 4; k++) if (int'(nb[k*2 +: 2]) > c) want_out = 1'b0;
          want_cnt = ref_count(c, nb, 1);
          n_cmp++;
          if (out_flag !== want_out) begin
            n_fail++; $display("FAIL sweep_out idx=%0d got=%b want=%b", idx, out_flag, want_out);
          end
          n_cmp++;
          if (out_count !== 3'(want_cnt)) begin
            n_fail++; $display("FAIL sweep_count idx=%0d got=%0d want=%0d", idx, out_count, want_cnt);
          end
        end
      end
    end
  endtask

  // center 2 vs nbrs {3,2,1,0} under each relation, thresh 3
  task automatic test_modes();
    int   exp_cnt [4] = '{2, 3, 1, 1};
    logic exp_out [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int idx;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) drive(1'b1, 2'd2, 8'b11_10_01_00, 2'(j), 3'd3);
      else       drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
      if (j >= 2) begin
        idx = j - 2;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL modes_valid m=%0d got=%b want=1", idx, out_valid); end
        n_cmp++;
        if (out_count !== 3'(exp_cnt[idx])) begin
          n_fail++; $display("FAIL modes_count m=%0d got=%0d want=%0d", idx, out_count, exp_cnt[idx]);
        end
        n_cmp++;
        if (out_flag !== exp_out[idx]) begin
          n_fail++; $display("FAIL modes_out m=%0d got=%b want=%b", idx, out_flag, exp_out[idx]);
        end
      end
    end
  endtask

  task automatic test_thresh_bounds();
    // No neighbour matches, but thresh 0 still flags
    drive(1'b1, 2'd0, 8'hFF, MODE_GT, 3'd0);
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL th0_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL th0_count got=%0d want=0", out_count); end
    n_cmp++; if (out_flag !== 1'b1) begin n_fail++; $display("FAIL th0_out got=%b want=1", out_flag); end
    // Same sample with thresh 1 must not flag
    drive(1'b1, 2'd0, 8'hFF, MODE_GT, 3'd1);
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    n_cmp++; if (out_flag !== 1'b0) begin n_fail++; $display("FAIL th1_out got=%b want=0", out_flag); end
    // N=5 build: all five match, thresh 7 still unreachable
    @(negedge clk);
    v5 = 1'b1; c5 = 2'd0; nbr5 = 10'd0; mode5 = MODE_GE; thresh5 = 3'd7;
    @(negedge clk);
    v5 = 1'b1; c5 = 2'd2; nbr5 = 10'b11_11_10_01_11; mode5 = MODE_GE; thresh5 = 3'd2;
    @(negedge clk);
    v5 = 1'b0;
    n_cmp++; if (ov5 !== 1'b1) begin n_fail++; $display("FAIL th7_valid got=%b want=1", ov5); end
    n_cmp++; if (cnt5 !== 3'd5) begin n_fail++; $display("FAIL th7_count got=%0d want=5", cnt5); end
    n_cmp++; if (o5 !== 1'b0) begin n_fail++; $display("FAIL th7_out got=%b want=0", o5); end
    @(negedge clk);
    n_cmp++; if (cnt5 !== 3'd2) begin n_fail++; $display("FAIL n5_count got=%0d want=2", cnt5); end
    n_cmp++; if (o5 !== 1'b1) begin n_fail++; $display("FAIL n5_out got=%b want=1", o5); end
  endtask

  // U, F, F, gap, F, F, F, U  (F = 4 matches, thresh 4; U = 0 matches)
  task automatic test_persistence();
    logic sv [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic sf [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic ev [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic eo [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic es [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int idx;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drive(sv[j], sf[j] ? 2'd3 : 2'd0, sf[j] ? 8'h00 : 8'hFF, MODE_GE, 3'd4);
      else       drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
      if (j >= 2) begin
        idx = j - 2;
        n_cmp++;
        if (out_valid !== ev[idx]) begin n_fail++; $display("FAIL hold_valid i=%0d got=%b want=%b", idx, out_valid, ev[idx]); end
        n_cmp++;
        if (out_flag !== eo[idx]) begin n_fail++; $display("FAIL hold_out i=%0d got=%b want=%b", idx, out_flag, eo[idx]); end
        n_cmp++;
        if (out_stable !== es[idx]) begin n_fail++; $display("FAIL hold_stable i=%0d got=%b want=%b", idx, out_stable, es[idx]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    // Build up a saturated run first
    for (int j = 0; j < 5; j++) begin
      if (j < 3) drive(1'b1, 2'd3, 8'h00, MODE_GE, 3'd4);
      else       drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    end
    n_cmp++; if (out_stable !== 1'b1) begin n_fail++; $display("FAIL rstm_pre_stable got=%b want=1", out_stable); end
    // Two flagged samples in flight when reset hits
    drive(1'b1, 2'd3, 8'h00, MODE_GE, 3'd4);
    drive(1'b1, 2'd3, 8'h00, MODE_GE, 3'd4);
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_valid0 got=%b want=0", out_valid); end
    n_cmp++; if (out_flag !== 1'b0) begin n_fail++; $display("FAIL rstm_out got=%b want=0", out_flag); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL rstm_count got=%0d want=0", out_count); end
    n_cmp++; if (out_stable !== 1'b0) begin n_fail++; $display("FAIL rstm_stable got=%b want=0", out_stable); end
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_valid1 got=%b want=0", out_valid); end
    // Fresh flagged sample after reset: one result, run restarts from zero
    drive(1'b1, 2'd3, 8'h00, MODE_GE, 3'd4);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_valid2 got=%b want=0", out_valid); end
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_early got=%b want=0", out_valid); end
    drive(1'b0, 2'd0, 8'd0, MODE_GT, 3'd0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstm_next_valid got=%b want=1", out_valid); end
    n_cmp++; if (out_flag !== 1'b1) begin n_fail++; $display("FAIL rstm_next_out got=%b want=1", out_flag); end
    n_cmp++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL rstm_next_count got=%0d want=4", out_count); end
    n_cmp++; if (out_stable !== 1'b0) begin n_fail++; $display("FAIL rstm_next_stable got=%b want=0", out_stable); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_modes();
    test_thresh_bounds();
    test_persistence();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
